// File: rtl/nvme_stream_arb_mux.sv
`default_nettype none
// =============================================================================
// Module   : nvme_stream_arb_mux
// Purpose  : N-channel packet stream mux with packet-boundary arbitration,
//            length truncation, misframe dropping and a 2-entry output buffer.
// Revision : 1.0 - initial release
// =============================================================================
module nvme_stream_arb_mux #(
    parameter int NUM_CH    = 4,
    parameter int DW        = 128,
    parameter int EX_W      = 16,
    parameter int SOP_BIT   = 15,
    parameter int EOP_BIT   = 14,
    parameter int PRIO_MODE = 0,
    parameter int MAX_BEATS = 64
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [NUM_CH*EX_W-1:0]   in_data_ex,
    input  logic [NUM_CH*DW-1:0]     in_data,
    input  logic [NUM_CH-1:0]        in_wen,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [EX_W-1:0]          out_data_ex,
    output logic [DW-1:0]            out_data,
    output logic                     out_wen,
    input  logic                     out_ready,
    output logic [NUM_CH+1:0]        ostat_inc,
    output logic [31:0]              ostatus_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_sel;
    logic [3:0]          r_last_grant;
    logic [15:0]         r_beat_cnt;
    logic [NUM_CH+1:0]   r_stat;
    logic [31:0]         r_dbg;

    logic [DW-1:0]       r_fifo_data [2];
    logic [EX_W-1:0]     r_fifo_ex   [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_cnt;

    logic [3:0]          w_start;
    logic [NUM_CH-1:0]   w_rot;
    logic [3:0]          w_off;
    logic [3:0]          w_sum;
    logic [3:0]          w_grant;
    logic                w_grant_sop;

    logic [NUM_CH-1:0]   w_sel_oh;
    logic [DW-1:0]       w_sel_data;
    logic [EX_W-1:0]     w_sel_ex;
    logic                w_sel_wen;
    logic                w_sel_eop;
    logic                w_rdy;
    logic                w_acc;
    logic                w_push;
    logic                w_pop;
    logic                w_trunc;
    logic [15:0]         w_beat_inc;
    logic [15:0]         w_beat_next;
    logic [EX_W-1:0]     w_push_ex;
    logic [7:0]          w_wen8;

    // Round-robin: rotate the request vector so bit 0 is the channel after
    // the last grant, take the lowest set bit, then rotate the index back.
    always_comb begin
        w_start = (r_last_grant >= 4'(NUM_CH - 1)) ? 4'd0 : r_last_grant + 4'd1;
        w_rot   = (NUM_CH)'({in_wen, in_wen} >> w_start);
        w_off   = 4'd0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = 4'(j);
        end
        w_sum   = w_start + w_off;
        w_grant = 4'd0;
        if (PRIO_MODE != 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (in_wen[i]) w_grant = 4'(i);
            end
        end else begin
            w_grant = (w_sum >= 4'(NUM_CH)) ? (w_sum - 4'(NUM_CH)) : w_sum;
        end
    end

    always_comb begin
        w_grant_sop = 1'b0;
        w_sel_oh    = '0;
        w_sel_data  = '0;
        w_sel_ex    = '0;
        w_sel_wen   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant == 4'(i)) w_grant_sop = in_data_ex[i*EX_W + SOP_BIT];
            if (r_sel == 4'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_sel_data  = in_data[i*DW +: DW];
                w_sel_ex    = in_data_ex[i*EX_W +: EX_W];
                w_sel_wen   = in_wen[i];
            end
        end
    end

    always_comb begin
        w_wen8             = '0;
        w_wen8[NUM_CH-1:0] = in_wen;
    end

    assign w_rdy       = ((r_state == S_XFER) && (r_cnt < 2'd2)) || (r_state == S_DROP);
    assign in_ready    = w_sel_oh & {NUM_CH{w_rdy}};
    assign w_acc       = w_sel_wen & w_rdy;
    assign w_push      = w_acc & (r_state == S_XFER);
    assign w_pop       = (r_cnt != 2'd0) & out_ready;
    assign w_sel_eop   = w_sel_ex[EOP_BIT];
    assign w_beat_inc  = r_beat_cnt + 16'd1;
    assign w_beat_next = (r_beat_cnt >= 16'(MAX_BEATS)) ? r_beat_cnt : w_beat_inc;
    // A beat that both ends the packet and hits the limit is a normal end.
    assign w_trunc     = (w_beat_inc == 16'(MAX_BEATS)) && !w_sel_eop;

    always_comb begin
        w_push_ex = w_sel_ex;
        if (w_trunc) w_push_ex[EOP_BIT] = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= S_IDLE;
            r_sel        <= 4'd0;
            r_last_grant <= 4'(NUM_CH - 1);
            r_beat_cnt   <= 16'd0;
            r_stat       <= '0;
            r_dbg        <= 32'd0;
        end else begin
            r_stat <= '0;
            r_dbg  <= {w_wen8, r_beat_cnt, r_cnt, r_sel, r_state};
            case (r_state)
                S_IDLE: begin
                    if (|in_wen) begin
                        r_sel        <= w_grant;
                        r_last_grant <= w_grant;
                        r_beat_cnt   <= 16'd0;
                        if (w_grant_sop) begin
                            r_state <= S_XFER;
                        end else begin
                            r_state          <= S_DROP;
                            r_stat[NUM_CH+1] <= 1'b1;
                        end
                    end
                end
                S_XFER: begin
                    if (w_acc) begin
                        r_beat_cnt <= w_beat_next;
                        if (w_sel_eop) begin
                            r_stat[NUM_CH-1:0] <= w_sel_oh;
                            r_state            <= S_IDLE;
                        end else if (w_trunc) begin
                            r_stat[NUM_CH] <= 1'b1;
                            r_state        <= S_DROP;
                        end
                    end
                end
                S_DROP: begin
                    if (w_acc && w_sel_eop) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                r_fifo_data[k] <= '0;
                r_fifo_ex[k]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_sel_data;
                r_fifo_ex[r_wr_ptr]   <= w_push_ex;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign out_wen     = (r_cnt != 2'd0);
    assign out_data    = r_fifo_data[r_rd_ptr];
    assign out_data_ex = r_fifo_ex[r_rd_ptr];
    assign ostat_inc   = r_stat;
    assign ostatus_dbg = r_dbg;

endmodule
`default_nettype wire

// File: tb/tb_nvme_stream_arb_mux.sv
`default_nettype none
// =============================================================================
// Module   : tb_nvme_stream_arb_mux
// Purpose  : Directed self-checking bench; instance 0 is round-robin with an
//            8-beat limit, instance 1 is fixed priority with a 4-beat limit.
// Revision : 1.0 - initial release
// =============================================================================
module tb_nvme_stream_arb_mux;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int EX_W   = 16;
    localparam logic [15:0] SOP = 16'h8000;
    localparam logic [15:0] EOP = 16'h4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][NUM_CH*EX_W-1:0] in_data_ex  = '0;
    logic [1:0][NUM_CH*DW-1:0]   in_data     = '0;
    logic [1:0][NUM_CH-1:0]      in_wen      = '0;
    logic [1:0][NUM_CH-1:0]      in_ready;
    logic [1:0][EX_W-1:0]        out_data_ex;
    logic [1:0][DW-1:0]          out_data;
    logic [1:0]                  out_wen;
    logic [1:0]                  out_ready   = '1;
    logic [1:0][NUM_CH+1:0]      ostat_inc;
    logic [1:0][31:0]            ostatus_dbg;

    nvme_stream_arb_mux #(.NUM_CH(NUM_CH), .DW(DW), .EX_W(EX_W), .SOP_BIT(15), .EOP_BIT(14),
                          .PRIO_MODE(0), .MAX_BEATS(8)) dut_rr (
        .sys_clk(clk), .sys_rst(rst),
        .in_data_ex(in_data_ex[0]), .in_data(in_data[0]), .in_wen(in_wen[0]), .in_ready(in_ready[0]),
        .out_data_ex(out_data_ex[0]), .out_data(out_data[0]), .out_wen(out_wen[0]), .out_ready(out_ready[0]),
        .ostat_inc(ostat_inc[0]), .ostatus_dbg(ostatus_dbg[0])
    );

    nvme_stream_arb_mux #(.NUM_CH(NUM_CH), .DW(DW), .EX_W(EX_W), .SOP_BIT(15), .EOP_BIT(14),
                          .PRIO_MODE(1), .MAX_BEATS(4)) dut_fp (
        .sys_clk(clk), .sys_rst(rst),
        .in_data_ex(in_data_ex[1]), .in_data(in_data[1]), .in_wen(in_wen[1]), .in_ready(in_ready[1]),
        .out_data_ex(out_data_ex[1]), .out_data(out_data[1]), .out_wen(out_wen[1]), .out_ready(out_ready[1]),
        .ostat_inc(ostat_inc[1]), .ostatus_dbg(ostatus_dbg[1])
    );

    logic [47:0] chq [2][NUM_CH][$];
    logic [47:0] oq  [2][$];
    int          st_cnt [2][NUM_CH+2];
    logic [1:0][NUM_CH-1:0] acc;
    int n_checks = 0;
    int n_fails  = 0;

    // Channel sources and output/statistics monitor: sample mid-cycle,
    // advance the per-channel beat queues just after the active edge.
    always begin
        logic [47:0] head;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            acc[d] = in_wen[d] & in_ready[d];
            if (out_wen[d] && out_ready[d]) oq[d].push_back({out_data_ex[d], out_data[d]});
            for (int j = 0; j < NUM_CH + 2; j++) if (ostat_inc[d][j]) st_cnt[d][j]++;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[d][i] && chq[d][i].size() > 0) head = chq[d][i].pop_front();
                if (chq[d][i].size() > 0) begin
                    head = chq[d][i][0];
                    in_wen[d][i]                  = 1'b1;
                    in_data[d][i*DW +: DW]        = head[31:0];
                    in_data_ex[d][i*EX_W +: EX_W] = head[47:32];
                end else begin
                    in_wen[d][i] = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_mon(input int d);
        oq[d].delete();
        for (int j = 0; j < NUM_CH + 2; j++) st_cnt[d][j] = 0;
    endtask

    task automatic push_beat(input int d, input int ch, input logic [31:0] data, input logic [15:0] ex);
        chq[d][ch].push_back({ex, data});
    endtask

    task automatic wait_done(input int d, input string name);
        int  left;
        bit  done;
        left = 300;
        done = 1'b0;
        while (!done && left > 0) begin
            tick(1);
            left--;
            done = (out_wen[d] == 1'b0);
            for (int c = 0; c < NUM_CH; c++) if (chq[d][c].size() != 0) done = 1'b0;
        end
        n_checks++;
        if (!done) begin
            n_fails++;
            $display("FAIL %s_timeout: inputs/output still busy after 300 cycles", name);
        end
        tick(3);
    endtask

    task automatic test_reset;
        tick(2);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({in_ready[d], out_wen[d], ostat_inc[d]} !== '0) begin
                n_fails++;
                $display("FAIL reset_ctl%0d: got ready=%b wen=%b stat=%b, expected all 0",
                         d, in_ready[d], out_wen[d], ostat_inc[d]);
            end
            n_checks++;
            if ({out_data[d], out_data_ex[d], ostatus_dbg[d]} !== '0) begin
                n_fails++;
                $display("FAIL reset_data%0d: got data=%h ex=%h dbg=%h, expected all 0",
                         d, out_data[d], out_data_ex[d], ostatus_dbg[d]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [47:0] got, exp;
        for (int rep = 0; rep < 2; rep++) begin
            clear_mon(0);
            for (int c = 0; c < NUM_CH; c++) begin
                push_beat(0, c, 32'hB00 + 32'(c * 16), SOP);
                push_beat(0, c, 32'hB01 + 32'(c * 16), EOP);
            end
            wait_done(0, "rr");
            n_checks++;
            if (oq[0].size() != 8) begin
                n_fails++;
                $display("FAIL rr_count rep%0d: got %0d beats, expected 8", rep, oq[0].size());
            end
            for (int k = 0; k < 8; k++) begin
                exp = {(k % 2 == 1) ? EOP : SOP, 32'hB00 + 32'((k / 2) * 16 + (k % 2))};
                got = (k < oq[0].size()) ? oq[0][k] : 'x;
                n_checks++;
                if (got !== exp) begin
                    n_fails++;
                    $display("FAIL rr_beat%0d rep%0d: got %h, expected %h", k, rep, got, exp);
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                n_checks++;
                if (st_cnt[0][c] != 1) begin
                    n_fails++;
                    $display("FAIL rr_stat%0d rep%0d: got %0d pulses, expected 1", c, rep, st_cnt[0][c]);
                end
            end
        end
    endtask

    task automatic test_fixed_priority;
        logic [47:0] got, exp;
        clear_mon(1);
        for (int p = 0; p < 4; p++) push_beat(1, 1, 32'h1100 + 32'(p), SOP | EOP);
        push_beat(1, 3, 32'h3300, SOP | EOP);
        wait_done(1, "prio");
        for (int k = 0; k < 5; k++) begin
            exp = {SOP | EOP, (k < 4) ? 32'h1100 + 32'(k) : 32'h3300};
            got = (k < oq[1].size()) ? oq[1][k] : 'x;
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL prio_beat%0d: got %h, expected %h", k, got, exp);
            end
        end
        n_checks++;
        if (st_cnt[1][1] != 4 || st_cnt[1][3] != 1) begin
            n_fails++;
            $display("FAIL prio_stat: got ch1=%0d ch3=%0d, expected 4 and 1", st_cnt[1][1], st_cnt[1][3]);
        end
    endtask

    task automatic test_single;
        logic [47:0] got, exp;
        logic [15:0] ex_tab [3];
        ex_tab[0] = 16'h8011;
        ex_tab[1] = 16'h0022;
        ex_tab[2] = 16'h4033;
        clear_mon(0);
        for (int b = 0; b < 3; b++) push_beat(0, 0, 32'hA0 + 32'(b), ex_tab[b]);
        wait_done(0, "single");
        n_checks++;
        if (oq[0].size() != 3) begin
            n_fails++;
            $display("FAIL single_count: got %0d beats, expected 3", oq[0].size());
        end
        for (int b = 0; b < 3; b++) begin
            exp = {ex_tab[b], 32'hA0 + 32'(b)};
            got = (b < oq[0].size()) ? oq[0][b] : 'x;
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL single_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        n_checks++;
        if (st_cnt[0][0] != 1 || st_cnt[0][4] != 0 || st_cnt[0][5] != 0) begin
            n_fails++;
            $display("FAIL single_stat: got ch0=%0d trunc=%0d drop=%0d, expected 1 0 0",
                     st_cnt[0][0], st_cnt[0][4], st_cnt[0][5]);
        end
        n_checks++;
        if (ostatus_dbg[0][1:0] !== 2'd0) begin
            n_fails++;
            $display("FAIL single_idle: got state %0d, expected 0", ostatus_dbg[0][1:0]);
        end
    endtask

    task automatic test_truncation;
        logic [47:0] got, exp;
        clear_mon(1);
        for (int b = 0; b < 6; b++)
            push_beat(1, 2, 32'h2200 + 32'(b), 16'h0002 | ((b == 0) ? SOP : 16'h0) | ((b == 5) ? EOP : 16'h0));
        wait_done(1, "trunc");
        n_checks++;
        if (oq[1].size() != 4) begin
            n_fails++;
            $display("FAIL trunc_count: got %0d beats, expected 4", oq[1].size());
        end
        for (int b = 0; b < 4; b++) begin
            exp = {16'h0002 | ((b == 0) ? SOP : 16'h0) | ((b == 3) ? EOP : 16'h0), 32'h2200 + 32'(b)};
            got = (b < oq[1].size()) ? oq[1][b] : 'x;
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL trunc_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        n_checks++;
        if (st_cnt[1][4] != 1 || st_cnt[1][2] != 0 || ostatus_dbg[1][1:0] !== 2'd0) begin
            n_fails++;
            $display("FAIL trunc_stat: got trunc=%0d ch2=%0d state=%0d, expected 1 0 0",
                     st_cnt[1][4], st_cnt[1][2], ostatus_dbg[1][1:0]);
        end
        // Exactly MAX_BEATS beats with EOP on the last one is a normal packet.
        clear_mon(1);
        for (int b = 0; b < 4; b++)
            push_beat(1, 2, 32'h2300 + 32'(b), ((b == 0) ? SOP : 16'h0) | ((b == 3) ? EOP : 16'h0));
        wait_done(1, "exact");
        n_checks++;
        if (oq[1].size() != 4 || st_cnt[1][2] != 1 || st_cnt[1][4] != 0) begin
            n_fails++;
            $display("FAIL exact_len: got beats=%0d ch2=%0d trunc=%0d, expected 4 1 0",
                     oq[1].size(), st_cnt[1][2], st_cnt[1][4]);
        end
        n_checks++;
        if (ostatus_dbg[1][23:8] !== 16'd4) begin
            n_fails++;
            $display("FAIL exact_beatcnt: got %0d, expected 4", ostatus_dbg[1][23:8]);
        end
    endtask

    task automatic test_framing;
        logic [47:0] got;
        clear_mon(0);
        push_beat(0, 1, 32'h5150, 16'h0000);
        push_beat(0, 1, 32'h5151, EOP);
        push_beat(0, 1, 32'h5152, SOP | EOP);
        wait_done(0, "frame");
        got = (oq[0].size() > 0) ? oq[0][0] : 'x;
        n_checks++;
        if (oq[0].size() != 1 || got !== {SOP | EOP, 32'h5152}) begin
            n_fails++;
            $display("FAIL frame_out: got %0d beats first %h, expected 1 beat c00000005152", oq[0].size(), got);
        end
        n_checks++;
        if (st_cnt[0][5] != 1 || st_cnt[0][1] != 1 || st_cnt[0][4] != 0) begin
            n_fails++;
            $display("FAIL frame_stat: got drop=%0d ch1=%0d trunc=%0d, expected 1 1 0",
                     st_cnt[0][5], st_cnt[0][1], st_cnt[0][4]);
        end
        clear_mon(0);
        push_beat(0, 2, 32'h5250, EOP);
        push_beat(0, 2, 32'h5251, SOP | EOP);
        wait_done(0, "frame1");
        got = (oq[0].size() > 0) ? oq[0][0] : 'x;
        n_checks++;
        if (oq[0].size() != 1 || got !== {SOP | EOP, 32'h5251}) begin
            n_fails++;
            $display("FAIL frame1_out: got %0d beats first %h, expected 1 beat c00000005251", oq[0].size(), got);
        end
        n_checks++;
        if (st_cnt[0][5] != 1 || st_cnt[0][2] != 1) begin
            n_fails++;
            $display("FAIL frame1_stat: got drop=%0d ch2=%0d, expected 1 1", st_cnt[0][5], st_cnt[0][2]);
        end
    endtask

    task automatic test_stall;
        logic [47:0] got, exp;
        out_ready[0] = 1'b0;
        clear_mon(0);
        for (int b = 0; b < 5; b++)
            push_beat(0, 0, 32'h5A0 + 32'(b), (b == 0) ? SOP : ((b == 4) ? EOP : 16'h0100));
        tick(10);
        n_checks++;
        if (out_wen[0] !== 1'b1 || ostatus_dbg[0][7:6] !== 2'd2 || ostatus_dbg[0][1:0] !== 2'd1) begin
            n_fails++;
            $display("FAIL stall_full: got wen=%b cnt=%0d state=%0d, expected 1 2 1",
                     out_wen[0], ostatus_dbg[0][7:6], ostatus_dbg[0][1:0]);
        end
        n_checks++;
        if (in_ready[0] !== 4'b0000 || chq[0][0].size() != 3 || oq[0].size() != 0) begin
            n_fails++;
            $display("FAIL stall_hold: got ready=%b pending=%0d out=%0d, expected 0000 3 0",
                     in_ready[0], chq[0][0].size(), oq[0].size());
        end
        out_ready[0] = 1'b1;
        wait_done(0, "stall");
        for (int b = 0; b < 5; b++) begin
            exp = {(b == 0) ? SOP : ((b == 4) ? EOP : 16'h0100), 32'h5A0 + 32'(b)};
            got = (b < oq[0].size()) ? oq[0][b] : 'x;
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL stall_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_packet;
        logic [47:0] got, exp;
        clear_mon(0);
        for (int b = 0; b < 6; b++)
            push_beat(0, 0, 32'h6600 + 32'(b), (b == 0) ? SOP : ((b == 5) ? EOP : 16'h0));
        tick(4);
        n_checks++;
        if (out_wen[0] !== 1'b1) begin
            n_fails++;
            $display("FAIL midrst_busy: got out_wen=%b before reset, expected 1", out_wen[0]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready[0], out_wen[0], ostat_inc[0], out_data[0], out_data_ex[0]} !== '0) begin
            n_fails++;
            $display("FAIL midrst_out: got ready=%b wen=%b stat=%b data=%h ex=%h, expected all 0",
                     in_ready[0], out_wen[0], ostat_inc[0], out_data[0], out_data_ex[0]);
        end
        for (int c = 0; c < NUM_CH; c++) chq[0][c].delete();
        tick(1);
        n_checks++;
        if (ostatus_dbg[0] !== 32'd0) begin
            n_fails++;
            $display("FAIL midrst_dbg: got %h, expected 0", ostatus_dbg[0]);
        end
        rst = 1'b0;
        clear_mon(0);
        push_beat(0, 3, 32'h7730, SOP);
        push_beat(0, 3, 32'h7731, EOP);
        wait_done(0, "postrst");
        for (int b = 0; b < 2; b++) begin
            exp = {(b == 0) ? SOP : EOP, 32'h7730 + 32'(b)};
            got = (b < oq[0].size()) ? oq[0][b] : 'x;
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL postrst_beat%0d: got %h, expected %h", b, got, exp);
            end
        end
        n_checks++;
        if (oq[0].size() != 2 || st_cnt[0][3] != 1 || st_cnt[0][0] != 0) begin
            n_fails++;
            $display("FAIL postrst_stat: got beats=%0d ch3=%0d ch0=%0d, expected 2 1 0",
                     oq[0].size(), st_cnt[0][3], st_cnt[0][0]);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        test_round_robin();
        test_fixed_priority();
        test_single();
        test_truncation();
        test_framing();
        test_stall();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
